// File: rtl/block_data_memory_pkg.sv
// Shared definitions for the block data memory and its users (e.g. the L1 cache).
//   - default geometry/latency constants
//   - FSM state encoding (2 bits)
//   - constant-foldable ceil(log2) helper used for index and counter widths
package block_data_memory_pkg;

  localparam int DMEM_DEFAULT_BLOCK_SIZE = 16;
  localparam int DMEM_DEFAULT_NUM_BLOCKS = 256;
  localparam int DMEM_DEFAULT_DELAY      = 50;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Smallest w with 2**w >= value.
  function automatic int dmem_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/block_data_memory_latency_counter.sv
// Latency down-counter for block_data_memory.
//   clk, reset : clock, synchronous active-high reset
//   i_load     : load DELAY-1 (request accepted)
//   i_en       : count down while the memory is busy
//   o_done     : enabled and the count has reached zero
// The count holds at zero, so it never underflows.
import block_data_memory_pkg::*;

module block_data_memory_latency_counter #(
  parameter int DELAY = DMEM_DEFAULT_DELAY
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam int CNT_W = dmem_clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY - 1);

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= LOAD_VAL;
    end else if (i_en && (r_value != '0)) begin
      r_value <= r_value - CNT_W'(1);
    end
  end

  assign o_done = i_en && (r_value == '0);

endmodule

// File: rtl/block_data_memory.sv
// Line-granular backing store behind the L1 data cache. One whole-block read
// or write in flight at a time; completion after a fixed DELAY cycles.
//   clk, reset      : clock, synchronous active-high reset (zeroes all blocks)
//   is_input_valid  : request present; accepted only when mem_ready
//   addr            : block address, low log2(NUM_BLOCKS) bits used
//   mem_read/write  : operation; both set is treated as a write
//   din / dout      : block write data / registered block read data
//   is_output_valid : one-cycle pulse when dout carries a completed read
//   mem_ready       : idle and able to accept a request
// Optional build macro DMEM_STATS_EN adds read_cnt, write_cnt and busy_cycles
// statistics counters; ports and timing are unchanged.
import block_data_memory_pkg::*;

module block_data_memory #(
  parameter int BLOCK_SIZE = DMEM_DEFAULT_BLOCK_SIZE,
  parameter int NUM_BLOCKS = DMEM_DEFAULT_NUM_BLOCKS,
  parameter int DELAY      = DMEM_DEFAULT_DELAY
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int DATA_W = BLOCK_SIZE * 8;
  localparam int IDX_W  = dmem_clog2(NUM_BLOCKS);

  dmem_state_e       r_state;
  dmem_state_e       w_state_next;
  logic              r_op_write;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_mem [NUM_BLOCKS];

  logic              w_accept;
  logic              w_busy;
  logic              w_done;
  logic [IDX_W-1:0]  w_idx;

  // Addresses wrap: upper bits alias onto the same blocks (NUM_BLOCKS is a power of two).
  assign w_idx  = IDX_W'(addr % NUM_BLOCKS);
  assign w_busy = (r_state == DMEM_BUSY);

  block_data_memory_latency_counter #(
    .DELAY (DELAY)
  ) u_latency (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_en   (w_busy),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= DMEM_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    mem_ready       = 1'b0;
    is_output_valid = 1'b0;
    case (r_state)
      DMEM_IDLE: begin
        mem_ready = 1'b1;
        if (is_input_valid && (mem_read || mem_write)) begin
          w_accept     = 1'b1;
          w_state_next = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        if (w_done) w_state_next = r_op_write ? DMEM_IDLE : DMEM_RESP;
      end
      DMEM_RESP: begin
        is_output_valid = 1'b1;
        w_state_next    = DMEM_IDLE;
      end
      default: w_state_next = DMEM_IDLE;
    endcase
  end

  // w_done is only ever high in BUSY, so it never coincides with an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_din      <= '0;
      r_dout     <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op_write <= mem_write;
        r_idx      <= w_idx;
        r_din      <= din;
      end
      if (w_done) begin
        if (r_op_write) r_mem[r_idx] <= r_din;
        else            r_dout       <= r_mem[r_idx];
      end
    end
  end

  assign dout = r_dout;

`ifdef DMEM_STATS_EN
  integer read_cnt;
  integer write_cnt;
  integer busy_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      read_cnt    <= 0;
      write_cnt   <= 0;
      busy_cycles <= 0;
    end else begin
      if (w_accept) begin
        if (mem_write) write_cnt <= write_cnt + 1;
        else           read_cnt  <= read_cnt + 1;
      end
      if (r_state != DMEM_IDLE) busy_cycles <= busy_cycles + 1;
    end
  end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
module tb_block_data_memory;

  localparam int BLOCK_SIZE = 16;
  localparam int NUM_BLOCKS = 256;
  localparam int DELAY      = 50;
  localparam int DW         = BLOCK_SIZE * 8;

  logic          clk;
  logic          reset;
  logic          is_input_valid;
  logic [31:0]   addr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] din;
  logic          is_output_valid;
  logic [DW-1:0] dout;
  logic          mem_ready;

  block_data_memory #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .NUM_BLOCKS (NUM_BLOCKS),
    .DELAY      (DELAY)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .mem_ready       (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            tests;
  int            fails;
  logic [DW-1:0] model [NUM_BLOCKS];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_read;

  task automatic clear_model();
    for (int i = 0; i < NUM_BLOCKS; i++) model[i] = '0;
    last_read = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
  endtask

  // Issues one request from a point just after a clock edge, then watches
  // until mem_ready returns. Reads push expected data when issued and pop
  // it when is_output_valid appears. m counts edges after the accept edge.
  task automatic do_op(input string name, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [DW-1:0] d, input bit disturb,
                       output int ready_at, output int pulse_at, output int pulses);
    int            idx;
    logic [DW-1:0] e;
    idx = int'(a & 32'(NUM_BLOCKS - 1));
    tests++;
    if (mem_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before: got %b expected 1", name, mem_ready);
    end
    is_input_valid = 1'b1;
    mem_read = rd;
    mem_write = wr;
    addr = a;
    din = d;
    if (!wr) exp_q.push_back(model[idx]);
    @(posedge clk);
    #1;
    is_input_valid = 1'b0;
    addr = $urandom;
    din = {$urandom, $urandom, $urandom, $urandom};
    ready_at = -1;
    pulse_at = -1;
    pulses = 0;
    for (int m = 1; m <= DELAY + 10; m++) begin
      @(posedge clk);
      #1;
      if (is_output_valid === 1'b1) begin
        pulses++;
        pulse_at = m;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s unexpected_pulse: got pulse at %0d expected none", name, m);
        end else begin
          e = exp_q.pop_front();
          last_read = e;
          if (dout !== e) begin
            fails++;
            $display("FAIL %s read_data: got %h expected %h", name, dout, e);
          end
        end
      end
      if (mem_ready === 1'b1) begin
        ready_at = m;
        break;
      end
      if (disturb && m == 10) begin
        is_input_valid = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b1;
        addr = 32'd5;
        din = {BLOCK_SIZE{8'hEE}};
      end
      if (disturb && m == 12) is_input_valid = 1'b0;
    end
    tests++;
    if (ready_at < 0) begin
      fails++;
      $display("FAIL %s timeout: got no mem_ready expected within %0d cycles", name, DELAY + 10);
    end
    if (wr && ready_at > 0) model[idx] = d;
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (mem_ready !== 1'b1 || is_output_valid !== 1'b0 || dout !== '0) begin
      fails++;
      $display("FAIL reset_state: got ready=%b valid=%b dout=%h expected 1 0 0",
               mem_ready, is_output_valid, dout);
    end
`ifdef DMEM_STATS_EN
    chk_int("reset_read_cnt", dut.read_cnt, 0);
    chk_int("reset_busy_cycles", dut.busy_cycles, 0);
`endif
  endtask

  task automatic test_write();
    int ra, pa, np;
    do_op("wr3", 1'b0, 1'b1, 32'd3, {BLOCK_SIZE{8'hA5}}, 1'b0, ra, pa, np);
    chk_int("wr3_ready_at", ra, DELAY);
    chk_int("wr3_pulses", np, 0);
  endtask

  task automatic test_read();
    int ra, pa, np;
    do_op("rd3", 1'b1, 1'b0, 32'd3, '0, 1'b0, ra, pa, np);
    chk_int("rd3_pulse_at", pa, DELAY);
    chk_int("rd3_ready_at", ra, DELAY + 1);
    chk_int("rd3_pulses", np, 1);
    do_op("rd7", 1'b1, 1'b0, 32'd7, '0, 1'b0, ra, pa, np);
    chk_int("rd7_pulses", np, 1);
  endtask

  task automatic test_busy_ignore();
    int ra, pa, np;
    do_op("wr3_disturbed", 1'b0, 1'b1, 32'd3, {BLOCK_SIZE{8'h3C}}, 1'b1, ra, pa, np);
    chk_int("wr3_disturbed_ready_at", ra, DELAY);
    do_op("rd5_untouched", 1'b1, 1'b0, 32'd5, '0, 1'b0, ra, pa, np);
    chk_int("rd5_pulses", np, 1);
    do_op("rd3_latched", 1'b1, 1'b0, 32'd3, '0, 1'b0, ra, pa, np);
    chk_int("rd3_latched_pulses", np, 1);
  endtask

  task automatic test_rw_alias();
    int            ra, pa, np;
    logic [DW-1:0] held;
    held = last_read;
    do_op("rw9", 1'b1, 1'b1, 32'd9, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
          1'b0, ra, pa, np);
    chk_int("rw9_ready_at", ra, DELAY);
    chk_int("rw9_pulses", np, 0);
    tests++;
    if (dout !== held) begin
      fails++;
      $display("FAIL dout_hold: got %h expected %h", dout, held);
    end
    do_op("rd_alias9", 1'b1, 1'b0, 32'(NUM_BLOCKS + 9), '0, 1'b0, ra, pa, np);
    chk_int("rd_alias9_pulses", np, 1);
  endtask

  task automatic test_reset_abort();
    int ra, pa, np;
    is_input_valid = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b1;
    addr = 32'd2;
    din = {BLOCK_SIZE{8'hF0}};
    @(posedge clk);
    #1 is_input_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
    tests++;
    if (mem_ready !== 1'b1 || is_output_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: got ready=%b valid=%b expected 1 0", mem_ready, is_output_valid);
    end
    do_op("rd2_aborted", 1'b1, 1'b0, 32'd2, '0, 1'b0, ra, pa, np);
    chk_int("rd2_pulses", np, 1);
    do_op("rd3_cleared", 1'b1, 1'b0, 32'd3, '0, 1'b0, ra, pa, np);
    chk_int("rd3_cleared_pulses", np, 1);
  endtask

  task automatic test_back_to_back();
    int ra, pa, np;
    apply_reset();
    do_op("b2b_wr4", 1'b0, 1'b1, 32'd4, {BLOCK_SIZE{8'h5A}}, 1'b0, ra, pa, np);
    chk_int("b2b_wr_ready_at", ra, DELAY);
    do_op("b2b_rd4", 1'b1, 1'b0, 32'd4, '0, 1'b0, ra, pa, np);
    chk_int("b2b_rd_pulse_at", pa, DELAY);
    chk_int("b2b_rd_ready_at", ra, DELAY + 1);
`ifdef DMEM_STATS_EN
    chk_int("stats_read_cnt", dut.read_cnt, 1);
    chk_int("stats_write_cnt", dut.write_cnt, 1);
    chk_int("stats_busy_cycles", dut.busy_cycles, 2 * DELAY + 1);
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    is_input_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    addr = '0;
    din = '0;
    clear_model();
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_rw_alias();
    test_reset_abort();
    test_back_to_back();
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
